// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-requester RAM port arbiter
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_e;
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep {valid, owner} shift register tracking reads in flight; ports clk, rst (sync active-low), in_vld/in_own -> out_vld/out_own
module rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_own,
  output logic out_vld,
  output logic out_own
);
  logic [RD_LAT-1:0] vld_q, own_q;
  logic [RD_LAT:0] vld_d, own_d;
  assign vld_d = {vld_q, in_vld};
  assign own_d = {own_q, in_own};
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d[RD_LAT-1:0];
      own_q <= own_d[RD_LAT-1:0];
    end
  end
  assign out_vld = vld_q[RD_LAT-1];
  assign out_own = own_q[RD_LAT-1];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin/priority arbiter sharing one RAM port between requesters A and B; ports a_*/b_* requester side, mem_* RAM side, conflict_cnt saturating tie counter
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1,
  parameter int PRIO_A = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);
  state_e state_q, state_d;
  logic rr_last_q, rr_last_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic a_elig, b_elig, both, tag_vld, tag_own;
  // the owner of the current cycle is masked so a req still high during its gnt cycle is not re-issued
  assign a_elig = a_req & (state_q != GNT_A);
  assign b_elig = b_req & (state_q != GNT_B);
  assign both = a_elig & b_elig;
  always_comb begin
    state_d = both ? ((PRIO_A != 0 || rr_last_q == OWN_B) ? GNT_A : GNT_B)
            : a_elig ? GNT_A : b_elig ? GNT_B : IDLE;
    rr_last_d = state_d == GNT_A ? OWN_A : state_d == GNT_B ? OWN_B : rr_last_q;
    we_d = state_d == GNT_A ? a_we : state_d == GNT_B ? b_we : 1'b0;
    addr_d = state_d == GNT_A ? a_addr : state_d == GNT_B ? b_addr : addr_q;
    wdata_d = state_d == GNT_A ? a_wdata : state_d == GNT_B ? b_wdata : wdata_q;
    cnt_d = (both && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_last_q <= OWN_B;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_last_q <= rr_last_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
    end
  end
  assign a_gnt = state_q == GNT_A;
  assign b_gnt = state_q == GNT_B;
  assign mem_en = state_q != IDLE;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign conflict_cnt = cnt_q;
  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk(clk),
    .rst(rst),
    .in_vld(mem_en & ~mem_we),
    .in_own(state_q == GNT_B),
    .out_vld(tag_vld),
    .out_own(tag_own)
  );
  assign a_rvalid = tag_vld & (tag_own == OWN_A);
  assign b_rvalid = tag_vld & (tag_own == OWN_B);
  assign a_rdata = a_rvalid ? mem_rdata : '0;
  assign b_rdata = b_rvalid ? mem_rdata : '0;
endmodule
